// File: rtl/epp_bridge_pkg.sv
// Shared definitions for the EPP-to-BRAM bridge.
// Contents:
//   state_e   - handshake FSM states.
//   REG_*     - EPP register-map addresses, selected by the 8-bit EPP
//               address register.
package epp_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADR      = 3'd1,
        S_DWR      = 3'd2,
        S_DRD_REQ  = 3'd3,
        S_DRD_WAIT = 3'd4,
        S_ACK      = 3'd5
    } state_e;

    localparam logic [7:0] REG_PTR_LO = 8'h00;
    localparam logic [7:0] REG_PTR_HI = 8'h01;
    localparam logic [7:0] REG_BANK   = 8'h02;
    localparam logic [7:0] REG_DATA   = 8'h03;
    localparam logic [7:0] REG_STAT   = 8'h04;

endpackage

// File: rtl/epp_sync.sv
// N-stage flop synchroniser for one asynchronous input bit.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset; loads RST_VAL into every stage
//   d_i - asynchronous input
//   q_o - synchronised output, N clk edges behind d_i
module epp_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] stage_q;
    logic [N:0]   shift_s;

    // Shift the new sample in at the bottom of the chain.
    always_comb begin
        shift_s = {stage_q, d_i};
    end

    // Synchroniser flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {N{RST_VAL}};
        end else begin
            stage_q <= shift_s[N-1:0];
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/epp_bram_bridge.sv
// EPP parallel-port slave that bridges host cycles to BRAM port A.
// Holds the EPP handshake FSM, an address register, an auto-incrementing
// pointer with sticky wrap status, and a bank selector.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   EppAstb, EppDstb       - async active-low address/data strobes
//   EppWr                  - async host write flag (low = write)
//   DB                     - bidirectional data bus, driven only in read ACK
//   EppWait                - handshake acknowledge
//   bram_en/we/addr/din    - BRAM port-A request
//   bram_dout              - read data from the selected bank
//   bank_sel               - selected bank
// Supported ADDR_W range: 9..16.
module epp_bram_bridge
    import epp_bridge_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int NUM_BANKS   = 4,
    parameter int RD_LAT      = 1,
    parameter int SYNC_STAGES = 2,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EppAstb,
    input  logic              EppDstb,
    input  logic              EppWr,
    inout  wire  [7:0]        DB,
    output logic              EppWait,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    input  logic [7:0]        bram_dout,
    output logic [BANK_W-1:0] bank_sel
);

    logic astb_s, dstb_s, wr_s;

    epp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_astb (
        .clk(clk), .rst(rst), .d_i(EppAstb), .q_o(astb_s));
    epp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dstb (
        .clk(clk), .rst(rst), .d_i(EppDstb), .q_o(dstb_s));
    epp_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wr (
        .clk(clk), .rst(rst), .d_i(EppWr), .q_o(wr_s));

    state_e              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [BANK_W-1:0]   pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                wrap_q, wrap_d;
    logic [7:0]          dout_q, dout_d;   // value presented on DB in read ACK
    logic [7:0]          din_q, din_d;     // DB sampled when the cycle starts
    logic                rd_q, rd_d;       // current cycle is a host read
    logic                astb_act_q, astb_act_d;  // address strobe owns cycle
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [7:0]          reg_rd_s;

    // Register-map read mux for non-data-port reads.
    always_comb begin
        reg_rd_s = 8'h00;
        case (addr_q)
            REG_PTR_LO: reg_rd_s = ptr_q[7:0];
            REG_PTR_HI: reg_rd_s = 8'(ptr_q >> 8);
            REG_BANK:   reg_rd_s = 8'(bank_q);
            REG_STAT:   reg_rd_s = {7'b0000000, wrap_q};
            default:    reg_rd_s = 8'h00;
        endcase
    end

    // Handshake FSM next state and datapath updates.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        bank_d     = bank_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        wrap_d     = wrap_q;
        dout_d     = dout_q;
        din_d      = din_q;
        rd_d       = rd_q;
        astb_act_d = astb_act_q;
        wcnt_d     = wcnt_q;
        en_d       = 1'b0;
        we_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Address strobe wins when both strobes are seen together.
                if (!astb_s) begin
                    state_d    = S_ADR;
                    rd_d       = wr_s;
                    astb_act_d = 1'b1;
                    din_d      = DB;
                end else if (!dstb_s) begin
                    rd_d       = wr_s;
                    astb_act_d = 1'b0;
                    din_d      = DB;
                    // BRAM strobes are registered so they coincide with the
                    // DWR / DRD_REQ cycle.
                    if (!wr_s) begin
                        state_d = S_DWR;
                        en_d    = (addr_q == REG_DATA);
                        we_d    = (addr_q == REG_DATA);
                    end else begin
                        state_d = S_DRD_REQ;
                        en_d    = (addr_q == REG_DATA);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADR: begin
                if (rd_q) begin
                    dout_d = addr_q;
                end else begin
                    addr_d = din_q;
                end
                state_d = S_ACK;
            end
            S_DWR: begin
                case (addr_q)
                    REG_PTR_LO: ptr_d = {ptr_q[ADDR_W-1:8], din_q};
                    REG_PTR_HI: ptr_d = ADDR_W'({din_q, ptr_q[7:0]});
                    REG_BANK: begin
                        // Out-of-range banks are dropped; legal ones wait for
                        // ACK to finish so bank_sel never moves mid-cycle.
                        if ({24'd0, din_q} < 32'(NUM_BANKS)) begin
                            pend_d     = BANK_W'(din_q);
                            pend_vld_d = 1'b1;
                        end else begin
                            pend_vld_d = pend_vld_q;
                        end
                    end
                    REG_DATA: begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        if (&ptr_q) begin
                            wrap_d = 1'b1;
                        end else begin
                            wrap_d = wrap_q;
                        end
                    end
                    default: ptr_d = ptr_q;
                endcase
                state_d = S_ACK;
            end
            S_DRD_REQ: begin
                if (addr_q == REG_DATA) begin
                    wcnt_d  = 2'd0;
                    state_d = S_DRD_WAIT;
                end else begin
                    dout_d = reg_rd_s;
                    if (addr_q == REG_STAT) begin
                        wrap_d = 1'b0;
                    end else begin
                        wrap_d = wrap_q;
                    end
                    state_d = S_ACK;
                end
            end
            S_DRD_WAIT: begin
                if (wcnt_q == 2'(RD_LAT - 1)) begin
                    dout_d = bram_dout;
                    ptr_d  = ptr_q + ADDR_W'(1);
                    if (&ptr_q) begin
                        wrap_d = 1'b1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_ACK: begin
                if ((astb_act_q && astb_s) || (!astb_act_q && dstb_s)) begin
                    state_d = S_IDLE;
                    if (pend_vld_q) begin
                        bank_d     = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        bank_d = bank_q;
                    end
                end else begin
                    state_d = S_ACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'h00;
            ptr_q      <= '0;
            bank_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            wrap_q     <= 1'b0;
            dout_q     <= 8'h00;
            din_q      <= 8'h00;
            rd_q       <= 1'b0;
            astb_act_q <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            wcnt_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            wrap_q     <= wrap_d;
            dout_q     <= dout_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            astb_act_q <= astb_act_d;
            en_q       <= en_d;
            we_q       <= we_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign EppWait   = (state_q == S_ACK);
    assign DB        = (state_q == S_ACK && rd_q) ? dout_q : 8'bzzzz_zzzz;
    assign bram_en   = en_q;
    assign bram_we   = we_q;
    assign bram_addr = ptr_q;
    assign bram_din  = din_q;
    assign bank_sel  = bank_q;

endmodule

// File: tb/tb_epp_bram_bridge.sv
module tb_epp_bram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        astb = 1'b1;
    logic        dstb = 1'b1;
    logic        eppwr = 1'b1;
    logic        host_oe = 1'b0;
    logic [7:0]  host_d = 8'h00;
    wire  [7:0]  db_w;
    logic        epp_wait;
    logic        bram_en, bram_we;
    logic [10:0] bram_addr;
    logic [7:0]  bram_din;
    logic [7:0]  bram_dout;
    logic [1:0]  bank_sel;

    int total = 0;
    int bad   = 0;

    assign db_w = host_oe ? host_d : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    epp_bram_bridge #(.ADDR_W(11), .NUM_BANKS(4), .RD_LAT(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .EppAstb(astb), .EppDstb(dstb), .EppWr(eppwr),
        .DB(db_w), .EppWait(epp_wait), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .bank_sel(bank_sel));

    // BRAM port-A model with two-cycle read latency, plus access counters.
    logic [7:0]  mem [0:8191];
    logic [7:0]  rd1, rd2;
    int          we_cnt = 0;
    int          en_cnt = 0;
    logic [10:0] last_we_addr = 11'd0;
    logic [7:0]  last_we_data = 8'h00;
    logic        pre_en = 1'b0;
    logic [12:0] pre_addr = 13'd0;
    logic [7:0]  pre_data = 8'h00;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (bram_en) begin
            en_cnt <= en_cnt + 1;
            rd1 <= mem[{bank_sel, bram_addr}];
            if (bram_we) begin
                mem[{bank_sel, bram_addr}] <= bram_din;
                we_cnt       <= we_cnt + 1;
                last_we_addr <= bram_addr;
                last_we_data <= bram_din;
            end
        end
        rd2 <= rd1;
    end
    assign bram_dout = rd2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete EPP cycle; lat = clk edges from strobe fall to EppWait high.
    task automatic epp(input bit is_addr, input bit is_wr, input logic [7:0] wdata,
                       output logic [7:0] rdata, output int lat);
        int n;
        @(posedge clk); #1;
        eppwr = is_wr ? 1'b0 : 1'b1;
        if (is_wr) begin
            host_oe = 1'b1;
            host_d  = wdata;
        end
        if (is_addr) astb = 1'b0; else dstb = 1'b0;
        lat = 0;
        while (!epp_wait && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ack_high", {31'd0, epp_wait}, 32'd1);
        rdata = db_w;
        astb = 1'b1;
        dstb = 1'b1;
        n = 0;
        while (epp_wait && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_low", {31'd0, epp_wait}, 32'd0);
        host_oe = 1'b0;
        eppwr   = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    logic [7:0] rd;
    int         lat;
    int         we0, en0;

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_wait", {31'd0, epp_wait}, 32'd0);
        chk("rst_en",   {31'd0, bram_en}, 32'd0);
        chk("rst_we",   {31'd0, bram_we}, 32'd0);
        chk("rst_ptr",  {21'd0, bram_addr}, 32'd0);
        chk("rst_bank", {30'd0, bank_sel}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Data writes through the data port
        epp(1'b1, 1'b1, 8'h03, rd, lat);
        chk("adr_lat", lat, 32'd4);
        epp(1'b0, 1'b1, 8'hA5, rd, lat);
        chk("wr1_addr", {21'd0, last_we_addr}, 32'd0);
        chk("wr1_data", {24'd0, last_we_data}, 32'hA5);
        epp(1'b0, 1'b1, 8'h5A, rd, lat);
        chk("wr2_addr", {21'd0, last_we_addr}, 32'd1);
        chk("wr2_data", {24'd0, last_we_data}, 32'h5A);
        chk("wr_pulses", we_cnt, 32'd2);
        chk("ptr_after_wr", {21'd0, bram_addr}, 32'd2);

        // Pointer wrap and sticky status
        epp(1'b1, 1'b1, 8'h00, rd, lat);
        epp(1'b0, 1'b1, 8'hFF, rd, lat);
        epp(1'b1, 1'b1, 8'h01, rd, lat);
        epp(1'b0, 1'b1, 8'h07, rd, lat);
        chk("ptr_7ff", {21'd0, bram_addr}, 32'h7FF);
        epp(1'b1, 1'b1, 8'h03, rd, lat);
        epp(1'b0, 1'b1, 8'hC3, rd, lat);
        chk("wrap_wr_addr", {21'd0, last_we_addr}, 32'h7FF);
        chk("ptr_wrapped", {21'd0, bram_addr}, 32'd0);
        epp(1'b1, 1'b1, 8'h04, rd, lat);
        epp(1'b0, 1'b0, 8'h00, rd, lat);
        chk("stat1", {24'd0, rd}, 32'h01);
        epp(1'b0, 1'b0, 8'h00, rd, lat);
        chk("stat2", {24'd0, rd}, 32'h00);

        // Data-port read with two-cycle BRAM latency
        pre_addr = 13'd5; pre_data = 8'h3C; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
        epp(1'b1, 1'b1, 8'h00, rd, lat);
        epp(1'b0, 1'b1, 8'h05, rd, lat);
        epp(1'b1, 1'b1, 8'h03, rd, lat);
        we0 = we_cnt;
        epp(1'b0, 1'b0, 8'h00, rd, lat);
        chk("rd_data", {24'd0, rd}, 32'h3C);
        chk("rd_lat", lat, 32'd6);
        chk("rd_ptr", {21'd0, bram_addr}, 32'd6);
        chk("rd_no_we", we_cnt, we0);

        // Bank select
        epp(1'b1, 1'b1, 8'h02, rd, lat);
        epp(1'b0, 1'b1, 8'h02, rd, lat);
        chk("bank2", {30'd0, bank_sel}, 32'd2);
        epp(1'b0, 1'b1, 8'h07, rd, lat);
        chk("bank_ignored", {30'd0, bank_sel}, 32'd2);
        epp(1'b0, 1'b0, 8'h00, rd, lat);
        chk("bank_rd", {24'd0, rd}, 32'h02);

        // Both strobes together: address cycle wins, no BRAM access
        en0 = en_cnt;
        @(posedge clk); #1;
        eppwr = 1'b0; host_oe = 1'b1; host_d = 8'h04;
        astb = 1'b0; dstb = 1'b0;
        for (int i = 0; i < 40 && !epp_wait; i++) begin
            @(posedge clk); #1;
        end
        chk("both_ack", {31'd0, epp_wait}, 32'd1);
        astb = 1'b1; dstb = 1'b1;
        for (int i = 0; i < 40 && epp_wait; i++) begin
            @(posedge clk); #1;
        end
        host_oe = 1'b0; eppwr = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("both_no_bram", en_cnt, en0);
        epp(1'b1, 1'b0, 8'h00, rd, lat);
        chk("adr_rd", {24'd0, rd}, 32'h04);
        epp(1'b1, 1'b1, 8'h10, rd, lat);
        epp(1'b0, 1'b0, 8'h00, rd, lat);
        chk("undef_rd", {24'd0, rd}, 32'h00);
        chk("undef_ptr", {21'd0, bram_addr}, 32'd6);

        // Glitch shorter than a clock: ignored
        en0 = en_cnt;
        epp(1'b1, 1'b1, 8'h03, rd, lat);
        en0 = en_cnt;
        @(posedge clk); #1;
        dstb = 1'b0;
        #2 dstb = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("glitch_wait", {31'd0, epp_wait}, 32'd0);
        chk("glitch_en", en_cnt, en0);

        // Reset during DRD_WAIT
        @(posedge clk); #1;
        eppwr = 1'b1; dstb = 1'b0;
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        we0 = we_cnt;
        @(posedge clk); #1;
        chk("mid_rst_wait", {31'd0, epp_wait}, 32'd0);
        chk("mid_rst_ptr", {21'd0, bram_addr}, 32'd0);
        chk("mid_rst_en", {31'd0, bram_en}, 32'd0);
        chk("mid_rst_bank", {30'd0, bank_sel}, 32'd0);
        dstb = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("mid_rst_no_we", we_cnt, we0);
        chk("post_rst_wait", {31'd0, epp_wait}, 32'd0);
        epp(1'b1, 1'b0, 8'h00, rd, lat);
        chk("post_rst_adr", {24'd0, rd}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/epp_bram_bridge.md
Name: epp_bram_bridge

Overview:
- Parametrised successor to the EPP-to-BRAM path: one block holds the EPP handshake FSM, a small register file and a multi-bank BRAM access port.
- Adds an auto-incrementing pointer, bank select, wrap status, a parametrised address width and a parametrised BRAM read latency.
- Sits between the parallel-port pins (DB, EppAstb, EppDstb, EppWr, EppWait) and port A of one or more dual-port BRAMs. Port B stays free for user logic.

Parameters:
- ADDR_W, 11, BRAM address width; pointer width.
- NUM_BANKS, 4, number of BRAM banks selected through bank_sel.
- RD_LAT, 1, BRAM read latency in clk cycles (1..3).
- SYNC_STAGES, 2, synchroniser depth on EppAstb, EppDstb and EppWr.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- EppAstb  in  1  EPP address strobe, active low, asynchronous.
- EppDstb  in  1  EPP data strobe, active low, asynchronous.
- EppWr  in  1  EPP write flag; low = host write.
- DB  inout  8  EPP data bus; driven only during host reads.
- EppWait  out  1  EPP wait/acknowledge, active high.
- bram_en  out  1  BRAM port-A enable.
- bram_we  out  1  BRAM port-A write enable.
- bram_addr  out  ADDR_W  BRAM port-A address (= pointer).
- bram_din  out  8  write data to BRAM.
- bram_dout  in  8  read data from the selected bank.
- bank_sel  out  clog2(NUM_BANKS)  selected bank.

Behaviour:
- Reset:
  - EppWait=0; DB high-Z; bram_en=0, bram_we=0.
  - Pointer=0, bank_sel=0, EPP address register=0, wrap flag=0, FSM=IDLE.
  - Reset asserted mid-transfer aborts the transfer immediately. No BRAM write is issued after the cycle rst is seen.
- Synchronisation and edge detection:
  - Strobes and EppWr pass through SYNC_STAGES flops.
  - The FSM acts on synchronised levels only.
- Register map (selected by the 8-bit EPP address register):
  - 0x00: pointer[7:0].
  - 0x01: pointer[ADDR_W-1:8], zero-extended on read.
  - 0x02: bank_sel. Writes with value >= NUM_BANKS are ignored.
  - 0x03: data port.
  - 0x04: status, read-only = {7'b0, wrap}. Reading it clears wrap.
  - Any other address: reads 0x00, writes ignored.
- FSM states: IDLE, ADR, DWR, DRD_REQ, DRD_WAIT, ACK.
  - IDLE -> ADR when Astb low. Astb has priority if both strobes are low together.
  - IDLE -> DWR when Dstb low and Wr low.
  - IDLE -> DRD_REQ when Dstb low and Wr high.
  - ADR, write: latch DB into the address register.
  - ADR, read: drive the address register on DB.
  - ADR -> ACK.
  - DWR, address 0x03: pulse bram_en=bram_we=1 for exactly one cycle with bram_din=DB, then increment the pointer.
  - DWR, other addresses: update the register.
  - DWR -> ACK.
  - DRD_REQ, address 0x03: pulse bram_en=1 for one cycle, then go to DRD_WAIT for RD_LAT cycles.
  - DRD_WAIT exit: capture bram_dout into the output register and increment the pointer.
  - DRD_REQ, other addresses: load the register value directly and go to ACK.
  - ACK: EppWait=1. For reads, DB is driven with the output register from ACK entry until the strobe returns high.
  - ACK -> IDLE when the active strobe reads high (synchronised). EppWait returns to 0 and DB to high-Z on the same edge.
- Latency (strobe low at pin -> EppWait high):
  - Register cycles: SYNC_STAGES+2 clk.
  - Data-port reads: SYNC_STAGES+2+RD_LAT clk.
- Pointer arithmetic:
  - Modulo 2^ADDR_W. Incrementing from all-ones wraps to 0 and sets the sticky wrap flag.
  - Read/write of register 0x03 increments; all other accesses do not.
- Bank selection: bank_sel is held constant while the FSM is outside IDLE. A bank write applies only after ACK completes.
- Ignored strobes: a strobe that returns high before the FSM leaves IDLE is ignored (glitch).

Decomposition:
- Package epp_bridge_pkg:
  - FSM state enum.
  - Register address constants REG_PTR_LO, REG_PTR_HI, REG_BANK, REG_DATA, REG_STAT.
- Sub-module epp_sync: parametrised N-stage synchroniser, instantiated 3×.

Test Plan:
- Address write 0x03, then data writes 0xA5, 0x5A: two single-cycle bram_we pulses at addr 0 and 1; pointer ends at 2; EppWait completes each handshake.
- Set ptr_lo=0xFF, ptr_hi=0x07 (ADDR_W=11), write data: write lands at 0x7FF, pointer becomes 0, status read returns 0x01, and a second status read returns 0x00.
- Preload BRAM[5]=0x3C, ptr=5, RD_LAT=2, data read: DB=0x3C while EppWait=1; EppWait rises SYNC_STAGES+4 clk after Dstb falls; pointer becomes 6.
- Bank write 0x02: bank_sel=2. Bank write 0x07 with NUM_BANKS=4: bank_sel stays 2. Read of register 0x02 returns 0x02.
- Assert rst while in DRD_WAIT: the next cycle has EppWait=0, DB high-Z, pointer=0, no bram_we pulse.
- Astb and Dstb fall in the same cycle with DB=0x04: the address register becomes 0x04 and no BRAM access occurs. An undefined address 0x10 reads as 0x00.
